hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
Pipeline-control block for the 5-stage RISC-V core. It consumes the ID/EX and IF/ID hazard view (the opposite end of the forwarding path) and drives the stall, bubble and flush controls that forwarding cannot resolve:
- load-use hazards,
- taken-branch flushes,
- multi-cycle MUL/DIV occupancy of EX, with a timeout watchdog.

It sits beside the forwarding unit and drives PC, IF/ID, ID/EX and EX/MEM register enables.

Parameters:
MD_TIMEOUT, 64, max cycles in MD_WAIT before abort (>=2)
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
IF_ID_Rs1  in  5  rs1 of instruction in ID
IF_ID_Rs2  in  5  rs2 of instruction in ID
IF_ID_UsesRs1  in  1  ID instruction reads rs1
IF_ID_UsesRs2  in  1  ID instruction reads rs2
ID_EX_Rd  in  5  rd of instruction in EX
ID_EX_MemRead  in  1  EX instruction is a load
EX_Branch_Taken  in  1  branch/jump resolved taken in EX
EX_MulDiv_Start  in  1  EX instruction is MUL/DIV, 1-cycle start pulse
MulDiv_Done  in  1  MUL/DIV result valid this cycle
PC_Write  out  1  PC register enable
IF_ID_Write  out  1  IF/ID register enable
ID_EX_Write  out  1  ID/EX register enable
IF_ID_Flush  out  1  clear IF/ID to NOP
ID_EX_Bubble  out  1  load NOP into ID/EX
EX_MEM_Bubble  out  1  load NOP into EX/MEM
MD_Timeout  out  1  sticky: MUL/DIV watchdog fired
Stall_Count  out  CNT_W  saturating count of cycles with PC_Write=0

Behaviour:
- States:
  - RUN
  - MD_WAIT
- Registers: state, wait counter (ceil(log2(MD_TIMEOUT+1)) bits), MD_Timeout, Stall_Count.
- Control outputs are combinational from state and inputs, with zero latency.
- Reset (sync, high):
  - next state RUN; wait counter=0; MD_Timeout=0; Stall_Count=0.
  - While reset is high: PC_Write=0, IF_ID_Write=0, ID_EX_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1, EX_MEM_Bubble=1.
  - Reset in MD_WAIT aborts the wait with no timeout flag.
- Default in RUN: PC_Write=IF_ID_Write=ID_EX_Write=1; all flush/bubble=0.
- Load-use in RUN:
  - hit = ID_EX_MemRead & ID_EX_Rd!=0 & ((UsesRs1 & Rs1==Rd) | (UsesRs2 & Rs2==Rd)).
  - On hit: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 for exactly that cycle; stay in RUN.
- Branch in RUN: EX_Branch_Taken=1 gives IF_ID_Flush=1 and ID_EX_Bubble=1, with PC_Write=1 and IF_ID_Write=1.
- Priority: branch overrides load-use. The stalled instruction is squashed, so PC_Write stays 1.
- MUL/DIV entry: EX_MulDiv_Start=1 in RUN with no branch:
  - PC_Write=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Bubble=1.
  - Next state MD_WAIT; wait counter=1.
  - If MulDiv_Done=1 in the same cycle: no stall, stay in RUN, defaults apply.
  - Start with Branch_Taken together is illegal; branch wins and start is ignored.
- MD_WAIT:
  - Hold PC_Write=IF_ID_Write=ID_EX_Write=0, EX_MEM_Bubble=1; load-use and branch inputs ignored.
  - MulDiv_Done=1: release that cycle (all enables 1, EX_MEM_Bubble=0); next RUN; counter=0.
  - Else if counter==MD_TIMEOUT: MD_Timeout<=1; enables 1, EX_MEM_Bubble=1 (result discarded); next RUN.
  - Else counter increments.
- MD_Timeout: sticky until reset.
- Stall_Count: increments on every non-reset cycle with PC_Write=0; saturates at 2^CNT_W-1 with no wrap.

Test Plan:
- Load-use: ID_EX_MemRead=1, Rd=5, Rs1=5, UsesRs1=1 for 1 cycle -> PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 that cycle only; Stall_Count 0->1.
- x0 and unused source: Rd=0 with Rs1=0, then Rd=7 with Rs2=7 and UsesRs2=0 -> no stall either case.
- Branch and load-use same cycle: Branch_Taken=1 plus hit -> IF_ID_Flush=1, ID_EX_Bubble=1, PC_Write=1; Stall_Count unchanged.
- MUL/DIV: Start pulse, Done 4 cycles later -> enables low 4 cycles plus release cycle high, EX_MEM_Bubble=0 on Done cycle; Stall_Count=4; state RUN after.
- Timeout: MD_TIMEOUT=8, Start, never Done -> stalled cycles = 8 (start cycle plus 7 counting cycles), release at counter==8, MD_Timeout=1 and stays 1; Stall_Count=8.
- Reset mid MD_WAIT and saturation: reset after 3 wait cycles -> RUN, flag 0, count 0. With CNT_W=4, 20 stall cycles -> Stall_Count=15.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Stall/bubble/flush control for the 5-stage core: load-use stalls, taken-branch
// flushes, and MUL/DIV occupancy of EX guarded by a timeout watchdog.
`timescale 1ns/1ps
module hazard_stall_unit #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_Rs1,
  input  logic [4:0]       IF_ID_Rs2,
  input  logic             IF_ID_UsesRs1,
  input  logic             IF_ID_UsesRs2,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             ID_EX_MemRead,
  input  logic             EX_Branch_Taken,
  input  logic             EX_MulDiv_Start,
  input  logic             MulDiv_Done,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             EX_MEM_Bubble,
  output logic             MD_Timeout,
  output logic [CNT_W-1:0] Stall_Count
);

  localparam int              WC_W   = $clog2(MD_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MD_TIMEOUT);
  localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);

  typedef enum logic {
    RUN,
    MD_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             md_timeout_q, md_timeout_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             load_use_hit;

  // x0 never carries a real dependency, so a load targeting it cannot stall.
  always_comb begin
    load_use_hit = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                   ((IF_ID_UsesRs1 && (IF_ID_Rs1 == ID_EX_Rd)) ||
                    (IF_ID_UsesRs2 && (IF_ID_Rs2 == ID_EX_Rd)));
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    md_timeout_d  = md_timeout_q;
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Bubble  = 1'b0;
    EX_MEM_Bubble = 1'b0;

    if (reset) begin
      state_d       = RUN;
      wait_cnt_d    = '0;
      md_timeout_d  = 1'b0;
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      IF_ID_Flush   = 1'b1;
      ID_EX_Bubble  = 1'b1;
      EX_MEM_Bubble = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (EX_Branch_Taken) begin
            // The would-be stalled instruction is squashed, so fetch keeps moving.
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
          end else if (EX_MulDiv_Start && !MulDiv_Done) begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
            state_d       = MD_WAIT;
            wait_cnt_d    = WC_ONE;
          end else if (load_use_hit) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
          end
        end

        MD_WAIT: begin
          if (MulDiv_Done) begin
            state_d    = RUN;
            wait_cnt_d = '0;
          end else if (wait_cnt_q == WC_MAX) begin
            // Watchdog release: pipeline resumes but the missing result is discarded.
            EX_MEM_Bubble = 1'b1;
            md_timeout_d  = 1'b1;
            state_d       = RUN;
            wait_cnt_d    = '0;
          end else begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
            wait_cnt_d    = wait_cnt_q + WC_ONE;
          end
        end

        default: begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      endcase
    end

    stall_count_d = stall_count_q;
    if (reset) begin
      stall_count_d = '0;
    end else if (!PC_Write && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    state_q       <= state_d;
    wait_cnt_q    <= wait_cnt_d;
    md_timeout_q  <= md_timeout_d;
    stall_count_q <= stall_count_d;
  end

  assign MD_Timeout  = md_timeout_q;
  assign Stall_Count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: load-use, branch priority, MUL/DIV wait,
// watchdog timeout, reset during a wait, and stall counter saturation.
`timescale 1ns/1ps
module tb_hazard_stall_unit;

  localparam int MD_TIMEOUT = 8;
  localparam int CNT_W      = 4;

  // Control vector order: PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Bubble
  localparam logic [5:0] CTL_RUN = 6'b111000;
  localparam logic [5:0] CTL_LU  = 6'b001010;
  localparam logic [5:0] CTL_BR  = 6'b111110;
  localparam logic [5:0] CTL_MD  = 6'b000001;
  localparam logic [5:0] CTL_TO  = 6'b111001;
  localparam logic [5:0] CTL_RST = 6'b000111;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       rs1, rs2, rd;
  logic             uses_rs1, uses_rs2, mem_read;
  logic             br_taken, md_start, md_done;
  logic             pc_write, if_id_write, id_ex_write;
  logic             if_id_flush, id_ex_bubble, ex_mem_bubble;
  logic             md_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [5:0]       ctrl;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .IF_ID_Rs1       (rs1),
    .IF_ID_Rs2       (rs2),
    .IF_ID_UsesRs1   (uses_rs1),
    .IF_ID_UsesRs2   (uses_rs2),
    .ID_EX_Rd        (rd),
    .ID_EX_MemRead   (mem_read),
    .EX_Branch_Taken (br_taken),
    .EX_MulDiv_Start (md_start),
    .MulDiv_Done     (md_done),
    .PC_Write        (pc_write),
    .IF_ID_Write     (if_id_write),
    .ID_EX_Write     (id_ex_write),
    .IF_ID_Flush     (if_id_flush),
    .ID_EX_Bubble    (id_ex_bubble),
    .EX_MEM_Bubble   (ex_mem_bubble),
    .MD_Timeout      (md_timeout),
    .Stall_Count     (stall_count)
  );

  assign ctrl = {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble, ex_mem_bubble};

  task automatic set_idle();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    uses_rs1 = 1'b0; uses_rs2 = 1'b0; mem_read = 1'b0;
    br_taken = 1'b0; md_start = 1'b0; md_done = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] r);
    mem_read = 1'b1; rd = r; rs1 = r; uses_rs1 = 1'b1;
  endtask

  // Drive at the falling edge, then let combinational outputs settle before sampling.
  task automatic next_cycle();
    @(negedge clk);
    set_idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_idle();
    reset = 1'b1;
    #2;
    vectors++;
    if (ctrl !== CTL_RST) begin
      $display("FAIL reset_ctrl: got %b expected %b", ctrl, CTL_RST);
      miscompares++;
    end
    next_cycle();
    reset = 1'b0;
    #2;
    vectors++;
    if (ctrl !== CTL_RUN) begin
      $display("FAIL post_reset_ctrl: got %b expected %b", ctrl, CTL_RUN);
      miscompares++;
    end
    vectors++;
    if (stall_count !== 4'd0 || md_timeout !== 1'b0) begin
      $display("FAIL post_reset_regs: count=%0d flag=%b expected 0/0", stall_count, md_timeout);
      miscompares++;
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use(5'd5);
    #2;
    vectors++;
    if (ctrl !== CTL_LU) begin
      $display("FAIL load_use_rs1: got %b expected %b", ctrl, CTL_LU);
      miscompares++;
    end
    next_cycle();
    #2;
    vectors++;
    if (ctrl !== CTL_RUN || stall_count !== 4'd1) begin
      $display("FAIL load_use_after: ctrl=%b count=%0d expected %b/1", ctrl, stall_count, CTL_RUN);
      miscompares++;
    end
    next_cycle();
    mem_read = 1'b1; rd = 5'd9; rs2 = 5'd9; uses_rs2 = 1'b1; rs1 = 5'd3; uses_rs1 = 1'b1;
    #2;
    vectors++;
    if (ctrl !== CTL_LU) begin
      $display("FAIL load_use_rs2: got %b expected %b", ctrl, CTL_LU);
      miscompares++;
    end
    next_cycle();
    #2;
    vectors++;
    if (stall_count !== 4'd2) begin
      $display("FAIL load_use_count: got %0d expected 2", stall_count);
      miscompares++;
    end
  endtask

  task automatic test_no_stall();
    do_reset();
    mem_read = 1'b1; rd = 5'd0; rs1 = 5'd0; uses_rs1 = 1'b1;
    #2;
    vectors++;
    if (ctrl !== CTL_RUN) begin
      $display("FAIL x0_dest: got %b expected %b", ctrl, CTL_RUN);
      miscompares++;
    end
    next_cycle();
    mem_read = 1'b1; rd = 5'd7; rs2 = 5'd7; uses_rs2 = 1'b0;
    #2;
    vectors++;
    if (ctrl !== CTL_RUN) begin
      $display("FAIL unused_rs2: got %b expected %b", ctrl, CTL_RUN);
      miscompares++;
    end
    next_cycle();
    mem_read = 1'b0; rd = 5'd4; rs1 = 5'd4; uses_rs1 = 1'b1;
    #2;
    vectors++;
    if (ctrl !== CTL_RUN) begin
      $display("FAIL non_load: got %b expected %b", ctrl, CTL_RUN);
      miscompares++;
    end
    next_cycle();
    #2;
    vectors++;
    if (stall_count !== 4'd0) begin
      $display("FAIL no_stall_count: got %0d expected 0", stall_count);
      miscompares++;
    end
  endtask

  task automatic test_branch_priority();
    do_reset();
    set_load_use(5'd5);
    br_taken = 1'b1;
    #2;
    vectors++;
    if (ctrl !== CTL_BR) begin
      $display("FAIL branch_over_load_use: got %b expected %b", ctrl, CTL_BR);
      miscompares++;
    end
    next_cycle();
    md_start = 1'b1;
    br_taken = 1'b1;
    #2;
    vectors++;
    if (ctrl !== CTL_BR) begin
      $display("FAIL branch_over_start: got %b expected %b", ctrl, CTL_BR);
      miscompares++;
    end
    next_cycle();
    #2;
    vectors++;
    if (ctrl !== CTL_RUN || stall_count !== 4'd0) begin
      $display("FAIL branch_after: ctrl=%b count=%0d expected %b/0", ctrl, stall_count, CTL_RUN);
      miscompares++;
    end
  endtask

  task automatic test_muldiv();
    do_reset();
    md_start = 1'b1;
    #2;
    vectors++;
    if (ctrl !== CTL_MD) begin
      $display("FAIL md_start: got %b expected %b", ctrl, CTL_MD);
      miscompares++;
    end
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      if (i == 2) begin
        set_load_use(5'd6);
        br_taken = 1'b1;
      end
      #2;
      vectors++;
      if (ctrl !== CTL_MD) begin
        $display("FAIL md_wait_%0d: got %b expected %b", i, ctrl, CTL_MD);
        miscompares++;
      end
    end
    next_cycle();
    md_done = 1'b1;
    #2;
    vectors++;
    if (ctrl !== CTL_RUN) begin
      $display("FAIL md_release: got %b expected %b", ctrl, CTL_RUN);
      miscompares++;
    end
    next_cycle();
    set_load_use(5'd8);
    #2;
    vectors++;
    if (ctrl !== CTL_LU || stall_count !== 4'd4 || md_timeout !== 1'b0) begin
      $display("FAIL md_after: ctrl=%b count=%0d flag=%b expected %b/4/0",
               ctrl, stall_count, md_timeout, CTL_LU);
      miscompares++;
    end
    next_cycle();
    md_start = 1'b1;
    md_done  = 1'b1;
    #2;
    vectors++;
    if (ctrl !== CTL_RUN) begin
      $display("FAIL md_same_cycle_done: got %b expected %b", ctrl, CTL_RUN);
      miscompares++;
    end
    next_cycle();
    #2;
    vectors++;
    if (ctrl !== CTL_RUN || stall_count !== 4'd5) begin
      $display("FAIL md_same_cycle_after: ctrl=%b count=%0d expected %b/5", ctrl, stall_count, CTL_RUN);
      miscompares++;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    md_start = 1'b1;
    #2;
    vectors++;
    if (ctrl !== CTL_MD) begin
      $display("FAIL to_start: got %b expected %b", ctrl, CTL_MD);
      miscompares++;
    end
    for (int i = 1; i <= 7; i++) begin
      next_cycle();
      #2;
      vectors++;
      if (ctrl !== CTL_MD || md_timeout !== 1'b0) begin
        $display("FAIL to_wait_%0d: ctrl=%b flag=%b expected %b/0", i, ctrl, md_timeout, CTL_MD);
        miscompares++;
      end
    end
    next_cycle();
    #2;
    vectors++;
    if (ctrl !== CTL_TO) begin
      $display("FAIL to_release: got %b expected %b", ctrl, CTL_TO);
      miscompares++;
    end
    next_cycle();
    #2;
    vectors++;
    if (ctrl !== CTL_RUN || md_timeout !== 1'b1 || stall_count !== 4'd8) begin
      $display("FAIL to_after: ctrl=%b flag=%b count=%0d expected %b/1/8",
               ctrl, md_timeout, stall_count, CTL_RUN);
      miscompares++;
    end
    repeat (3) next_cycle();
    #2;
    vectors++;
    if (md_timeout !== 1'b1) begin
      $display("FAIL to_sticky: got %b expected 1", md_timeout);
      miscompares++;
    end
  endtask

  // Runs straight after the timeout test so the sticky flag is set going in.
  task automatic test_reset_mid_wait();
    next_cycle();
    md_start = 1'b1;
    repeat (3) next_cycle();
    #2;
    vectors++;
    if (ctrl !== CTL_MD) begin
      $display("FAIL rmw_waiting: got %b expected %b", ctrl, CTL_MD);
      miscompares++;
    end
    next_cycle();
    reset = 1'b1;
    #2;
    vectors++;
    if (ctrl !== CTL_RST) begin
      $display("FAIL rmw_reset_ctrl: got %b expected %b", ctrl, CTL_RST);
      miscompares++;
    end
    next_cycle();
    reset = 1'b0;
    #2;
    vectors++;
    if (ctrl !== CTL_RUN || md_timeout !== 1'b0 || stall_count !== 4'd0) begin
      $display("FAIL rmw_after: ctrl=%b flag=%b count=%0d expected %b/0/0",
               ctrl, md_timeout, stall_count, CTL_RUN);
      miscompares++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      set_load_use(5'd10);
      @(negedge clk);
      #2;
      if (i == 14 || i == 15 || i == 20) begin
        vectors++;
        if (stall_count !== ((i < 15) ? 4'(i) : 4'd15)) begin
          $display("FAIL sat_%0d: got %0d expected %0d", i, stall_count, (i < 15) ? i : 15);
          miscompares++;
        end
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_priority();
    test_muldiv();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
